// File: rtl/crc_pkg.sv
// Shared CRC definitions: polynomials, MSB-first byte steppers and the
// framing FSM state type used by crc_stream_accumulator.
package crc_pkg;

  localparam logic [7:0]  CRC8_POLY  = 8'h07;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // One byte into a CRC-8 remainder, MSB first, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] rem, input logic [7:0] data);
    logic [7:0] r;
    r = rem ^ data;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ CRC8_POLY) : (r << 1);
    end
    return r;
  endfunction

  // One byte into a CRC-16 remainder; the byte enters at the top bits.
  function automatic logic [15:0] crc16_step(input logic [15:0] rem, input logic [7:0] data);
    logic [15:0] r;
    r = rem ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ CRC16_POLY) : (r << 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Combinational next-remainder logic for both CRCs, one byte per call.
module crc_byte_step
  import crc_pkg::*;
(
  input  logic [7:0]  crc8_cur,
  input  logic [15:0] crc16_cur,
  input  logic [7:0]  data,
  output logic [7:0]  crc8_nxt,
  output logic [15:0] crc16_nxt
);

  always_comb begin
    crc8_nxt  = crc8_step(crc8_cur, data);
    crc16_nxt = crc16_step(crc16_cur, data);
  end

endmodule

// File: rtl/crc_stream_accumulator.sv
// Framing stage: accumulates CRC-8/CRC-16 and length over a byte stream and
// holds a registered result until the downstream consumer accepts it.
module crc_stream_accumulator
  import crc_pkg::*;
#(
  parameter logic [7:0]  CRC8_INIT  = 8'h00,
  parameter logic [15:0] CRC16_INIT = 16'h0000,
  parameter int          LEN_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_crc8,
  output logic [15:0]      m_crc16,
  output logic [LEN_W-1:0] m_len,
  output logic             m_len_ovf,
  output state_e           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid holds its payload stable until it transfers, and ready
  // never depends combinationally on valid (s_ready is simply !m_valid, registered).

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_e           state_q;
  logic [7:0]       crc8_q;
  logic [15:0]      crc16_q;
  logic [LEN_W-1:0] cnt_q;
  logic             ovf_q;

  logic [7:0]       crc8_nxt;
  logic [15:0]      crc16_nxt;
  logic [LEN_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             beat;

  crc_byte_step u_step (
    .crc8_cur  (crc8_q),
    .crc16_cur (crc16_q),
    .data      (s_data),
    .crc8_nxt  (crc8_nxt),
    .crc16_nxt (crc16_nxt)
  );

  assign beat      = s_valid && s_ready;
  assign dbg_state = state_q;

  always_comb begin
    cnt_nxt = (cnt_q == LEN_MAX) ? cnt_q : cnt_q + LEN_W'(1);
    ovf_nxt = ovf_q | (cnt_q == LEN_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      crc8_q    <= CRC8_INIT;
      crc16_q   <= CRC16_INIT;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_crc8    <= CRC8_INIT;
      m_crc16   <= CRC16_INIT;
      m_len     <= '0;
      m_len_ovf <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          s_ready <= 1'b1;
          if (flush) begin
            // A beat offered alongside flush is swallowed, even with s_last.
            state_q <= IDLE;
            crc8_q  <= CRC8_INIT;
            crc16_q <= CRC16_INIT;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end else if (beat) begin
            if (s_last) begin
              m_crc8    <= crc8_nxt;
              m_crc16   <= crc16_nxt;
              m_len     <= cnt_nxt;
              m_len_ovf <= ovf_nxt;
              m_valid   <= 1'b1;
              s_ready   <= 1'b0;
              state_q   <= HOLD;
              crc8_q    <= CRC8_INIT;
              crc16_q   <= CRC16_INIT;
              cnt_q     <= '0;
              ovf_q     <= 1'b0;
            end else begin
              crc8_q  <= crc8_nxt;
              crc16_q <= crc16_nxt;
              cnt_q   <= cnt_nxt;
              ovf_q   <= ovf_nxt;
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream_accumulator.sv
// Directed bench for crc_stream_accumulator: known-answer frames, backpressure,
// flush, reset aborts and length saturation on a narrow-counter instance.
module tb_crc_stream_accumulator;
  import crc_pkg::*;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_crc8;
  logic [15:0] m_crc16;
  logic [15:0] m_len;
  logic        m_len_ovf;
  state_e      dbg_state;

  logic        s_valid2;
  logic        s_ready2;
  logic        m_valid2;
  logic        m_ready2;
  logic [7:0]  m_crc8_2;
  logic [15:0] m_crc16_2;
  logic [2:0]  m_len2;
  logic        m_len_ovf2;
  state_e      dbg_state2;

  int checks = 0;
  int errors = 0;
  int n_results = 0;
  logic [40:0] exp_q[$];
  logic [7:0]  msg [9];

  crc_stream_accumulator dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .flush(flush), .m_valid(m_valid),
    .m_ready(m_ready), .m_crc8(m_crc8), .m_crc16(m_crc16), .m_len(m_len),
    .m_len_ovf(m_len_ovf), .dbg_state(dbg_state)
  );

  crc_stream_accumulator #(.LEN_W(3)) dut_small (
    .clk(clk), .reset(reset), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_data(s_data), .s_last(s_last), .flush(flush), .m_valid(m_valid2),
    .m_ready(m_ready2), .m_crc8(m_crc8_2), .m_crc16(m_crc16_2), .m_len(m_len2),
    .m_len_ovf(m_len_ovf2), .dbg_state(dbg_state2)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [40:0] pack(input logic ovf, input logic [15:0] len,
                                       input logic [15:0] c16, input logic [7:0] c8);
    return {ovf, len, c16, c8};
  endfunction

  // Scoreboard: every accepted result must match the head of exp_q.
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      n_results++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {63'd0, m_valid}, 64'd0);
      end else begin
        chk("result", {23'd0, pack(m_len_ovf, m_len, m_crc16, m_crc8)}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks: start and end on a falling edge.
  task automatic send_byte(input logic [7:0] d, input logic last);
    bit done;
    done = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int k = 0; k < 50 && !done; k++) begin
      if (s_ready) done = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("byte_accepted", {63'd0, done}, 64'd1);
  endtask

  task automatic send_msg();
    for (int i = 0; i < 9; i++) send_byte(msg[i], i == 8);
  endtask

  initial begin
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; flush = 1'b0;
    m_ready = 1'b1; s_valid2 = 1'b0; m_ready2 = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_m_crc8", {56'd0, m_crc8}, 64'h00);
    chk("rst_m_crc16", {48'd0, m_crc16}, 64'h0000);
    chk("rst_m_len", {48'd0, m_len}, 64'd0);
    chk("rst_m_len_ovf", {63'd0, m_len_ovf}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, {62'd0, IDLE});
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", {63'd0, s_ready}, 64'd1);

    // Known answer "123456789", m_ready high
    exp_q.push_back(pack(1'b0, 16'd9, 16'h31C3, 8'hF4));
    send_msg();
    chk("kat_m_valid_rise", {63'd0, m_valid}, 64'd1);
    chk("kat_state_hold", {62'd0, dbg_state}, {62'd0, HOLD});
    chk("kat_s_ready_low", {63'd0, s_ready}, 64'd0);
    @(negedge clk);
    chk("kat_m_valid_pulse", {63'd0, m_valid}, 64'd0);
    chk("kat_s_ready_back", {63'd0, s_ready}, 64'd1);
    chk("kat_len_kept", {48'd0, m_len}, 64'd9);

    // Single-byte frame
    exp_q.push_back(pack(1'b0, 16'd1, 16'h1021, 8'h07));
    send_byte(8'h01, 1'b1);
    chk("single_m_valid", {63'd0, m_valid}, 64'd1);
    @(negedge clk);

    // Backpressure with a second frame waiting
    m_ready = 1'b0;
    exp_q.push_back(pack(1'b0, 16'd9, 16'h31C3, 8'hF4));
    send_msg();
    s_valid = 1'b1; s_data = msg[0]; s_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_s_ready", {63'd0, s_ready}, 64'd0);
      chk("bp_m_valid", {63'd0, m_valid}, 64'd1);
      chk("bp_crc8", {56'd0, m_crc8}, 64'hF4);
      chk("bp_crc16", {48'd0, m_crc16}, 64'h31C3);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_m_valid", {63'd0, m_valid}, 64'd0);
    exp_q.push_back(pack(1'b0, 16'd9, 16'h31C3, 8'hF4));
    send_msg();
    chk("bp_second_m_valid", {63'd0, m_valid}, 64'd1);
    @(negedge clk);

    // Flush mid-frame, including a dropped s_last beat
    begin
      int n0;
      n0 = n_results;
      for (int i = 0; i < 4; i++) send_byte(msg[i], 1'b0);
      flush = 1'b1; s_valid = 1'b1; s_data = 8'h01; s_last = 1'b1;
      @(negedge clk);
      flush = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      chk("flush_state_idle", {62'd0, dbg_state}, {62'd0, IDLE});
      chk("flush_no_valid", {63'd0, m_valid}, 64'd0);
      exp_q.push_back(pack(1'b0, 16'd9, 16'h31C3, 8'hF4));
      send_msg();
      chk("flush_m_valid", {63'd0, m_valid}, 64'd1);
      @(negedge clk);
      chk("flush_one_result", n_results, n0 + 1);
    end

    // Reset mid-frame and in HOLD
    begin
      int n0;
      n0 = n_results;
      for (int i = 0; i < 4; i++) send_byte(msg[i], 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_s_ready", {63'd0, s_ready}, 64'd0);
      chk("rst_mid_crc8", {56'd0, m_crc8}, 64'h00);
      chk("rst_mid_crc16", {48'd0, m_crc16}, 64'h0000);
      chk("rst_mid_len", {48'd0, m_len}, 64'd0);
      chk("rst_mid_state", {62'd0, dbg_state}, {62'd0, IDLE});
      reset = 1'b0;
      @(negedge clk);
      m_ready = 1'b0;
      send_msg();
      chk("rst_hold_m_valid_pre", {63'd0, m_valid}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_hold_m_valid", {63'd0, m_valid}, 64'd0);
      chk("rst_hold_crc8", {56'd0, m_crc8}, 64'h00);
      chk("rst_hold_len", {48'd0, m_len}, 64'd0);
      reset = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      exp_q.push_back(pack(1'b0, 16'd9, 16'h31C3, 8'hF4));
      send_msg();
      chk("rst_after_m_valid", {63'd0, m_valid}, 64'd1);
      @(negedge clk);
      chk("rst_one_result", n_results, n0 + 1);
    end

    // Narrow counter: 10 bytes (nine zeros then 0x01) against LEN_W=3
    m_ready2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("small_s_ready", {63'd0, s_ready2}, 64'd1);
      s_valid2 = 1'b1;
      s_data = (i == 9) ? 8'h01 : 8'h00;
      s_last = (i == 9);
      @(negedge clk);
    end
    s_valid2 = 1'b0; s_last = 1'b0;
    chk("small_m_valid", {63'd0, m_valid2}, 64'd1);
    chk("small_len_sat", {61'd0, m_len2}, 64'd7);
    chk("small_ovf", {63'd0, m_len_ovf2}, 64'd1);
    chk("small_crc8", {56'd0, m_crc8_2}, 64'h07);
    chk("small_crc16", {48'd0, m_crc16_2}, 64'h1021);
    m_ready2 = 1'b1;
    @(negedge clk);
    chk("small_m_valid_drop", {63'd0, m_valid2}, 64'd0);
    chk("small_ovf_kept", {63'd0, m_len_ovf2}, 64'd1);
    s_valid2 = 1'b1; s_data = 8'h01; s_last = 1'b1;
    @(negedge clk);
    s_valid2 = 1'b0; s_last = 1'b0;
    chk("small_next_len", {61'd0, m_len2}, 64'd1);
    chk("small_next_ovf", {63'd0, m_len_ovf2}, 64'd0);
    @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_stream_accumulator.md
# crc_stream_accumulator

Sequential framing stage that sits in front of the byte-wise combinational CRC steppers (CRC-8 poly 0x07, CRC-16 poly 0x1021). It accepts a byte stream with a valid/ready handshake and frame delimiting, and holds the running remainders in registers. At end of frame it presents the final CRC-8, the final CRC-16 and the frame length on a registered result port. The result is held until a downstream consumer accepts it.

## Interface
- CRC8_INIT, 8'h00, CRC-8 remainder value at the start of every frame
- CRC16_INIT, 16'h0000, CRC-16 remainder value at the start of every frame
- LEN_W, 16, width of the frame byte counter
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s_valid  in  1  input byte valid
- s_ready  out  1  block can accept a byte
- s_data  in  8  input byte, MSB-first into the CRC
- s_last  in  1  qualifies s_data as the final byte of the frame
- flush  in  1  synchronous discard of the frame in progress
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_crc8  out  8  final CRC-8
- m_crc16  out  16  final CRC-16
- m_len  out  LEN_W  byte count of the frame, saturating
- m_len_ovf  out  1  frame length exceeded 2^LEN_W-1

## Operation
- No reflection and no final XOR. With default inits, "123456789" gives CRC-8 0xF4 and CRC-16 0x31C3.
- A beat transfers when s_valid && s_ready.
- States:
  - IDLE: remainders at init, count 0. A beat moves to ACCUM, or to HOLD if s_last is set.
  - ACCUM: each beat updates the remainders and increments the count. A beat with s_last moves to HOLD.
  - HOLD: m_valid=1 and s_ready=0. On m_ready, move to IDLE.
- On the last beat, the updated remainders and count (including that byte) are latched into m_crc8, m_crc16 and m_len.
- m_len saturates at 2^LEN_W-1. m_len_ovf is set if any beat arrives while the count is saturated. Both clear on the next frame start.
- Flush in IDLE or ACCUM:
  - Remainders return to init, count returns to 0, state goes to IDLE.
  - A beat presented in the same cycle is consumed and dropped, including an s_last beat.
- Flush in HOLD is ignored; the held result is never discarded.
- A frame has at least 1 byte. There is no zero-length frame.

## Timing
- Reset values: s_ready=0 while reset is asserted, then 1 from the first cycle after deassertion. m_valid=0, m_crc8=CRC8_INIT, m_crc16=CRC16_INIT, m_len=0, m_len_ovf=0. State is IDLE.
- Throughput is one byte per cycle within a frame.
- Result latency: m_valid rises on the clock edge that accepts the s_last beat, so it is visible the cycle after the last beat.
- s_ready is registered and equals !m_valid.
- The cycle after the m_valid && m_ready handshake, m_valid=0 and s_ready=1. This gives a minimum one-cycle bubble between frames.
- m_crc8, m_crc16, m_len and m_len_ovf are stable while m_valid=1. They keep their last value after the handshake.
- Reset mid-frame or in HOLD aborts immediately. No partial result is ever emitted.

## Structure
- Shared package crc_pkg holds:
  - CRC8_POLY=8'h07 and CRC16_POLY=16'h1021
  - functions crc8_step(rem, byte) and crc16_step(rem, byte), each a bitwise loop of 8 shifts, MSB-first
  - the state enum typedef (IDLE, ACCUM, HOLD)
- One sub-module, crc_byte_step: purely combinational. It instantiates both step functions and yields the next remainders from the current remainders and s_data.
- The top level holds the FSM, remainder registers, counter and output registers.

## Test plan
- Frame "123456789", one beat per cycle, m_ready=1: m_crc8=0xF4, m_crc16=0x31C3, m_len=9. m_valid is high for 1 cycle, 1 cycle after the last beat.
- Single-byte frame 0x01 with s_last set: m_crc8=0x07, m_crc16=0x1021, m_len=1.
- Backpressure: m_ready=0 for 5 cycles after the result of "123456789", with a second frame offered. s_ready stays 0, the result stays stable at 0xF4/0x31C3, and no second-frame bytes are consumed. After m_ready, the second frame gives the same result.
- Flush after "1234", then the full "123456789": one result only, 0xF4/0x31C3/9.
- Reset asserted after 4 bytes and in the middle of HOLD: outputs return to reset values. A subsequent "123456789" gives 0xF4/0x31C3.
- LEN_W=3, 10-byte frame: m_len=7 and m_len_ovf=1. The CRCs still cover all 10 bytes.
